// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types, constants and sizing helper for the calculator datapath
package calc_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

   localparam int BCD_DIGIT_W = 4;

   // Decimal digits needed for a WIDTH-bit unsigned value: ceil(width * log10(2)).
   function automatic int min_digits(input int width);
      longint scaled;
      scaled = longint'(width) * 64'sd30103 + 64'sd99999;
      return int'(scaled / 64'sd100000);
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_digit_adj
   import calc_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_i,
   output logic [BCD_DIGIT_W-1:0] digit_o
);

   assign digit_o = (digit_i >= BCD_DIGIT_W'(5)) ? digit_i + BCD_DIGIT_W'(3) : digit_i;

endmodule

// File: rtl/result_bcd_converter.sv
// rtl/result_bcd_converter.sv - sequential binary-to-BCD converter, one shift per clock
module result_bcd_converter
   import calc_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              value,
   input  logic                          signed_mode,
   input  logic                          ovr_in,
   output logic                          out_valid,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
   output logic                          neg,
   output logic                          err
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int BCD_W = BCD_DIGIT_W * DIGITS;

   if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
      $error("result_bcd_converter: DIGITS too small for WIDTH");
   end

   state_e               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [WIDTH-1:0]     mag_q;
   logic [BCD_W-1:0]     scratch_q;
   logic                 neg_r_q;
   logic                 err_r_q;
   logic [BCD_W-1:0]     bcd_q;
   logic                 neg_q;
   logic                 err_q;
   logic                 out_valid_q;

   logic                 neg_in_d;
   logic [WIDTH-1:0]     mag_in_d;
   logic [BCD_W-1:0]     scratch_adj_d;
   logic [BCD_W+WIDTH-1:0] shift_d;

   assign neg_in_d = signed_mode & value[WIDTH-1];
   // Two's-complement negate; the most negative value maps onto its own magnitude.
   assign mag_in_d = neg_in_d ? (~value + WIDTH'(1)) : value;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (scratch_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .digit_o (scratch_adj_d[i*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   assign shift_d = {scratch_adj_d, mag_q} << 1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mag_q       <= '0;
         scratch_q   <= '0;
         neg_r_q     <= 1'b0;
         err_r_q     <= 1'b0;
         bcd_q       <= '0;
         neg_q       <= 1'b0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  mag_q     <= mag_in_d;
                  neg_r_q   <= neg_in_d;
                  err_r_q   <= ovr_in;
                  scratch_q <= '0;
                  cnt_q     <= CNT_W'(WIDTH);
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch_q <= shift_d[BCD_W+WIDTH-1:WIDTH];
               mag_q     <= shift_d[WIDTH-1:0];
               cnt_q     <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               bcd_q       <= scratch_q;
               neg_q       <= neg_r_q;
               err_q       <= err_r_q;
               out_valid_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Held low during reset so upstream never sees a ready it cannot use.
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign bcd       = bcd_q;
   assign neg       = neg_q;
   assign err       = err_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// tb/tb_result_bcd_converter.sv - self-checking bench for result_bcd_converter
module tb_result_bcd_converter;

   localparam int W = 8;
   localparam int D = 3;
   localparam int LAT = W + 1;

   logic           clk;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   value;
   logic           signed_mode;
   logic           ovr_in;
   logic           out_valid;
   logic [4*D-1:0] bcd;
   logic           neg;
   logic           err;

   int n_checks;
   int n_fail;

   result_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .value       (value),
      .signed_mode (signed_mode),
      .ovr_in      (ovr_in),
      .out_valid   (out_valid),
      .bcd         (bcd),
      .neg         (neg),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: signed interpretation via integer arithmetic, digits by repeated /10.
   function automatic logic [4*D-1:0] ref_bcd(input logic [W-1:0] v, input logic sm);
      int mag;
      logic [4*D-1:0] r;
      mag = (sm && v[W-1]) ? ((1 << W) - int'(v)) % (1 << W) : int'(v);
      r = '0;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(mag % 10);
         mag = mag / 10;
      end
      return r;
   endfunction

   function automatic logic ref_neg(input logic [W-1:0] v, input logic sm);
      return sm && (int'(v) >= (1 << (W - 1)));
   endfunction

   // Presents one word, waits for the result; lat = -1 if no out_valid within budget.
   task automatic convert(input logic [W-1:0] v, input logic sm, input logic ov, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      value = v; signed_mode = sm; ovr_in = ov; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = -1;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; value = 8'hFF; signed_mode = 1'b0; ovr_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_checks++;
      if ({out_valid, bcd, neg, err} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: ov=%b bcd=%h neg=%b err=%b want all 0", out_valid, bcd, neg, err);
      end
      rst = 1'b0; in_valid = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_fixed_vectors();
      logic [W-1:0]   tv [7] = '{8'hFF, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h80, 8'h2A};
      logic           ts [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic           to [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [4*D-1:0] tb [7] = '{12'h255, 12'h128, 12'h001, 12'h000, 12'h000, 12'h128, 12'h042};
      logic           tn [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      int lat;
      for (int i = 0; i < 7; i++) begin
         convert(tv[i], ts[i], to[i], lat);
         n_checks++;
         if (lat != LAT) begin n_fail++; $display("FAIL fixed_latency[%0d]: got %0d want %0d", i, lat, LAT); end
         n_checks++;
         if ({bcd, neg, err} !== {tb[i], tn[i], to[i]}) begin
            n_fail++;
            $display("FAIL fixed_result[%0d]: bcd=%h neg=%b err=%b want bcd=%h neg=%b err=%b",
                     i, bcd, neg, err, tb[i], tn[i], to[i]);
         end
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL out_valid_pulse_width: got %b want 0", out_valid); end
   endtask

   task automatic test_err_clear();
      int lat;
      convert(8'h2A, 1'b0, 1'b1, lat);
      n_checks++;
      if (err !== 1'b1 || bcd !== 12'h042) begin n_fail++; $display("FAIL err_set: err=%b bcd=%h want 1/042", err, bcd); end
      convert(8'h2A, 1'b0, 1'b0, lat);
      n_checks++;
      if (err !== 1'b0 || lat != LAT) begin n_fail++; $display("FAIL err_clear: err=%b lat=%0d want 0/%0d", err, lat, LAT); end
   endtask

   task automatic test_random();
      logic [W-1:0] v;
      logic sm, ov;
      int lat;
      for (int i = 0; i < 24; i++) begin
         v = W'($urandom); sm = 1'($urandom); ov = 1'($urandom);
         convert(v, sm, ov, lat);
         n_checks++;
         if (lat != LAT || bcd !== ref_bcd(v, sm) || neg !== ref_neg(v, sm) || err !== ov) begin
            n_fail++;
            $display("FAIL random[%0d] v=%h sm=%b: lat=%0d bcd=%h neg=%b err=%b want lat=%0d bcd=%h neg=%b err=%b",
                     i, v, sm, lat, bcd, neg, err, LAT, ref_bcd(v, sm), ref_neg(v, sm), ov);
         end
      end
   endtask

   task automatic test_hold();
      int lat;
      int seen;
      convert(8'd123, 1'b0, 1'b0, lat);
      value = 8'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (bcd !== 12'h123 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL hold_mid_shift: bcd=%h ov=%b want 123/0", bcd, out_valid);
      end
      seen = 0;
      for (int n = 0; n < 20 && seen == 0; n++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      n_checks++;
      if (seen != 1 || bcd !== 12'h005) begin n_fail++; $display("FAIL hold_next: seen=%0d bcd=%h want 1/005", seen, bcd); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a, b;
      logic [4*D-1:0] got [$];
      int acc_at [$];
      a = 8'd200 + W'($urandom_range(0, 55));
      b = W'($urandom_range(0, 199));
      @(posedge clk); #1;
      value = a; signed_mode = 1'b0; ovr_in = 1'b0; in_valid = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (out_valid) got.push_back(bcd);
         if (in_ready && in_valid) acc_at.push_back(n);
         @(posedge clk); #1;
         if (acc_at.size() == 1) value = b;
         if (acc_at.size() == 2) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      n_checks++;
      if (got.size() != 2 || acc_at.size() != 2) begin
         n_fail++; $display("FAIL b2b_counts: pulses=%0d accepts=%0d want 2/2", got.size(), acc_at.size());
      end else begin
         n_checks++;
         if (got[0] !== ref_bcd(a, 1'b0) || got[1] !== ref_bcd(b, 1'b0)) begin
            n_fail++; $display("FAIL b2b_values: got %h,%h want %h,%h", got[0], got[1], ref_bcd(a, 1'b0), ref_bcd(b, 1'b0));
         end
         n_checks++;
         if (acc_at[1] - acc_at[0] != W + 2) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", acc_at[1] - acc_at[0], W + 2);
         end
      end
   endtask

   task automatic test_reset_abort();
      int lat;
      int pulses;
      convert(8'h80, 1'b1, 1'b1, lat);
      value = 8'h37; signed_mode = 1'b0; ovr_in = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, bcd, neg, err, in_ready} !== '0) begin
         n_fail++; $display("FAIL abort_outputs: ov=%b bcd=%h neg=%b err=%b rdy=%b want all 0", out_valid, bcd, neg, err, in_ready);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", in_ready); end
      pulses = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      n_checks++;
      if (pulses != 0) begin n_fail++; $display("FAIL abort_no_pulse: got %0d want 0", pulses); end
      convert(8'd99, 1'b0, 1'b0, lat);
      n_checks++;
      if (lat != LAT || {bcd, neg, err} !== {12'h099, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL abort_fresh: lat=%0d bcd=%h neg=%b err=%b want %0d/099/0/0", lat, bcd, neg, err, LAT);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      rst = 1'b1; in_valid = 1'b0; value = '0; signed_mode = 1'b0; ovr_in = 1'b0;
      test_reset();
      test_fixed_vectors();
      test_err_clear();
      test_random();
      test_hold();
      test_back_to_back();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
